// File: rtl/bsg_ready_and_link_wormhole_rr_conc.sv
// N-way ready/and link concentrator: packet-granular round-robin on requests,
// order FIFO steers in-order responses back to the input that issued them.
module bsg_ready_and_link_wormhole_rr_conc #(
  parameter int width_p      = 32,
  parameter int num_in_p     = 4,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0,
  parameter int order_els_p  = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_in_p-1:0][width_p+1:0]   links_i,
  output logic [num_in_p-1:0][width_p+1:0]   links_o,
  input  logic [width_p+1:0]                 single_link_i,
  output logic [width_p+1:0]                 single_link_o
);
  // link layout: {v, ready_and_rev, data}
  localparam int v_bit_lp     = width_p + 1;
  localparam int r_bit_lp     = width_p;
  localparam int lg_num_in_lp = (num_in_p == 1) ? 1 : $clog2(num_in_p);
  localparam int ptr_w_lp     = $clog2(order_els_p);
  localparam int cnt_w_lp     = $clog2(order_els_p + 1);

  logic                    req_lock_q, req_lock_d;
  logic [lg_num_in_lp-1:0] req_owner_q, req_owner_d;
  logic [lg_num_in_lp-1:0] rr_last_q, rr_last_d;
  logic [len_width_p-1:0]  req_cnt_q, req_cnt_d;
  logic                    resp_lock_q, resp_lock_d;
  logic [len_width_p-1:0]  resp_cnt_q, resp_cnt_d;

  logic [lg_num_in_lp-1:0] fifo_mem_q [order_els_p];
  logic [ptr_w_lp-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
  logic [cnt_w_lp-1:0]     count_q, count_d;

  logic                    fifo_full, fifo_empty, push, pop;
  logic                    rr_found;
  logic [lg_num_in_lp-1:0] rr_sel, sel, head;
  logic                    req_v, req_xfer, resp_ok, resp_xfer;
  logic [len_width_p-1:0]  req_len, resp_len;

  assign fifo_full  = (count_q == cnt_w_lp'(order_els_p));
  assign fifo_empty = (count_q == '0);

  // Scan from farthest to nearest so the nearest valid input after rr_last wins.
  always_comb begin
    int idx;
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int i = num_in_p; i >= 1; i--) begin
      idx = (int'(rr_last_q) + i) % num_in_p;
      if (links_i[idx][v_bit_lp]) begin
        rr_found = 1'b1;
        rr_sel   = idx[lg_num_in_lp-1:0];
      end
    end
  end

  assign sel      = req_lock_q ? req_owner_q : rr_sel;
  assign req_v    = ~reset_i & (req_lock_q ? links_i[req_owner_q][v_bit_lp]
                                           : (rr_found & ~fifo_full));
  assign req_xfer = req_v & single_link_i[r_bit_lp];
  assign req_len  = links_i[sel][len_offset_p +: len_width_p];
  assign push     = req_xfer & ~req_lock_q;

  assign head      = fifo_mem_q[rptr_q];
  assign resp_ok   = ~reset_i & ~fifo_empty;
  assign resp_xfer = resp_ok & single_link_i[v_bit_lp] & links_i[head][r_bit_lp];
  assign resp_len  = single_link_i[len_offset_p +: len_width_p];

  always_comb begin
    req_lock_d  = req_lock_q;
    req_owner_d = req_owner_q;
    req_cnt_d   = req_cnt_q;
    rr_last_d   = rr_last_q;
    if (push) begin
      rr_last_d = sel;
      if (req_len != '0) begin
        req_lock_d  = 1'b1;
        req_owner_d = sel;
        req_cnt_d   = req_len;
      end
    end else if (req_xfer) begin
      req_cnt_d = req_cnt_q - len_width_p'(1);
      if (req_cnt_q == len_width_p'(1)) req_lock_d = 1'b0;
    end
  end

  // The order FIFO pops on the response tail flit.
  always_comb begin
    resp_lock_d = resp_lock_q;
    resp_cnt_d  = resp_cnt_q;
    pop         = 1'b0;
    if (resp_xfer) begin
      if (!resp_lock_q) begin
        if (resp_len == '0) pop = 1'b1;
        else begin
          resp_lock_d = 1'b1;
          resp_cnt_d  = resp_len;
        end
      end else begin
        resp_cnt_d = resp_cnt_q - len_width_p'(1);
        if (resp_cnt_q == len_width_p'(1)) begin
          resp_lock_d = 1'b0;
          pop         = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = (wptr_q == ptr_w_lp'(order_els_p - 1)) ? '0 : wptr_q + ptr_w_lp'(1);
    if (pop)  rptr_d = (rptr_q == ptr_w_lp'(order_els_p - 1)) ? '0 : rptr_q + ptr_w_lp'(1);
    if (push && !pop)      count_d = count_q + cnt_w_lp'(1);
    else if (!push && pop) count_d = count_q - cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_lock_q  <= 1'b0;
      req_owner_q <= '0;
      req_cnt_q   <= '0;
      rr_last_q   <= lg_num_in_lp'(num_in_p - 1);
      resp_lock_q <= 1'b0;
      resp_cnt_q  <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
    end else begin
      req_lock_q  <= req_lock_d;
      req_owner_q <= req_owner_d;
      req_cnt_q   <= req_cnt_d;
      rr_last_q   <= rr_last_d;
      resp_lock_q <= resp_lock_d;
      resp_cnt_q  <= resp_cnt_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wptr_q] <= sel;
  end

  always_comb begin
    single_link_o                = '0;
    single_link_o[v_bit_lp]      = req_v;
    single_link_o[r_bit_lp]      = resp_ok & links_i[head][r_bit_lp];
    single_link_o[width_p-1:0]   = links_i[sel][width_p-1:0];
    for (int k = 0; k < num_in_p; k++) begin
      links_o[k]               = '0;
      links_o[k][width_p-1:0]  = single_link_i[width_p-1:0];
      links_o[k][v_bit_lp]     = resp_ok & single_link_i[v_bit_lp] & (head == lg_num_in_lp'(k));
      links_o[k][r_bit_lp]     = req_v & single_link_i[r_bit_lp] & (sel == lg_num_in_lp'(k));
    end
  end

endmodule

// File: tb/tb_bsg_ready_and_link_wormhole_rr_conc.sv
// Bench for the wormhole round-robin concentrator: vector table, scoreboard of
// concentrated request flits, and hand sequences for locking, full FIFO and reset.
module tb_bsg_ready_and_link_wormhole_rr_conc;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]   in_v, in_ready;
  logic [W-1:0] in_data [N];
  logic         single_v, single_rdy;
  logic [W-1:0] single_data;

  logic [N-1:0][W+1:0] links_i, links_o, links2_o;
  logic [W+1:0]        single_link_i, single_link_o, single2_o;

  always_comb begin
    for (int k = 0; k < N; k++) links_i[k] = {in_v[k], in_ready[k], in_data[k]};
    single_link_i = {single_v, single_rdy, single_data};
  end

  logic [3:0] lo_v, lo_rdy, lo2_rdy;
  logic       so_v, so_rdy, so2_v, so2_rdy;
  logic [W-1:0] so_data;
  always_comb begin
    for (int k = 0; k < N; k++) begin
      lo_v[k]    = links_o[k][W+1];
      lo_rdy[k]  = links_o[k][W];
      lo2_rdy[k] = links2_o[k][W];
    end
    so_v    = single_link_o[W+1];
    so_rdy  = single_link_o[W];
    so_data = single_link_o[W-1:0];
    so2_v   = single2_o[W+1];
    so2_rdy = single2_o[W];
  end

  bsg_ready_and_link_wormhole_rr_conc #(
    .width_p(W), .num_in_p(N), .len_width_p(4), .len_offset_p(0), .order_els_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset), .links_i(links_i), .links_o(links_o),
    .single_link_i(single_link_i), .single_link_o(single_link_o)
  );

  bsg_ready_and_link_wormhole_rr_conc #(
    .width_p(W), .num_in_p(N), .len_width_p(4), .len_offset_p(0), .order_els_p(2)
  ) dut2 (
    .clk_i(clk), .reset_i(reset), .links_i(links_i), .links_o(links2_o),
    .single_link_i(single_link_i), .single_link_o(single2_o)
  );

  int chk = 0;
  int err = 0;
  logic [W-1:0] exp_q [$];
  logic sb_en = 1'b1;

  typedef struct {
    logic [3:0] vm;
    logic       sr;
    logic [3:0] em;
    logic       ev;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard pop on every concentrated transfer, then advance one cycle.
  task automatic cyc();
    logic [W-1:0] e;
    if (sb_en && so_v && single_rdy) begin
      if (exp_q.size() == 0) check("sb_unexpected", so_data, 'x);
      else begin
        e = exp_q.pop_front();
        check("sb_flit", so_data, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic req(input logic [3:0] vm, input logic sr, input logic [3:0] em,
                     input logic ev, input string nm);
    in_v = vm; single_rdy = sr;
    #2;
    check({nm, "_v"}, so_v, ev);
    check({nm, "_rdy"}, lo_rdy, em);
    for (int k = 0; k < N; k++) if (em[k]) exp_q.push_back(in_data[k]);
    cyc();
  endtask

  task automatic rsp(input logic [W-1:0] d, input logic [3:0] rm, input logic [3:0] ev,
                     input logic er, input string nm);
    single_v = 1'b1; single_data = d; in_ready = rm;
    #2;
    check({nm, "_v"}, lo_v, ev);
    check({nm, "_srdy"}, so_rdy, er);
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_v = '0; single_v = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  logic [W-1:0] flits [4];
  logic         srdy_pat [5];
  int           fi;

  initial begin
    tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1};
    tbl[1] = '{4'b1110, 1'b1, 4'b0010, 1'b1};
    tbl[2] = '{4'b1100, 1'b1, 4'b0100, 1'b1};
    tbl[3] = '{4'b1000, 1'b1, 4'b1000, 1'b1};
    tbl[4] = '{4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[5] = '{4'b1010, 1'b1, 4'b1000, 1'b1};
    tbl[6] = '{4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[7] = '{4'b0001, 1'b0, 4'b0000, 1'b1};
    tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    flits[0] = 8'h83; flits[1] = 8'h91; flits[2] = 8'h92; flits[3] = 8'h93;
    srdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    for (int k = 0; k < N; k++) in_data[k] = 8'(k << 6);
    in_ready = 4'hF; single_rdy = 1'b1; single_data = '0;

    // Reset with every input active: all handshake outputs must be quiet.
    reset = 1'b1; in_v = 4'hF; single_v = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    #2;
    check("rst_so_v", so_v, 1'b0);
    check("rst_so_rdy", so_rdy, 1'b0);
    check("rst_lo_v", lo_v, 4'h0);
    check("rst_lo_rdy", lo_rdy, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0; single_v = 1'b0;

    // Round-robin table: grants 0..3, then 3/1 alternation skipping idle inputs.
    for (int i = 0; i < 9; i++)
      req(tbl[i].vm, tbl[i].sr, tbl[i].em, tbl[i].ev, $sformatf("tbl%0d", i));

    // FIFO holds 0,1,2,3,1,3,1; responses must follow that order.
    rsp(8'h00, 4'hF, 4'b0001, 1'b1, "rsp0");
    rsp(8'h00, 4'hF, 4'b0010, 1'b1, "rsp1");
    rsp(8'h00, 4'hF, 4'b0100, 1'b1, "rsp2");
    rsp(8'h00, 4'hF, 4'b1000, 1'b1, "rsp3");
    rsp(8'h00, 4'hF, 4'b0010, 1'b1, "rsp4");
    rsp(8'h02, 4'b0111, 4'b1000, 1'b0, "rsp3_stall");
    rsp(8'h02, 4'hF, 4'b1000, 1'b1, "rsp3_hdr");
    rsp(8'h10, 4'hF, 4'b1000, 1'b1, "rsp3_b1");
    rsp(8'h11, 4'hF, 4'b1000, 1'b1, "rsp3_b2");
    rsp(8'h00, 4'hF, 4'b0010, 1'b1, "rsp1_tail");
    rsp(8'h00, 4'hF, 4'b0000, 1'b0, "rsp_empty");
    single_v = 1'b0;

    // Input 2 len=3 packet holds the grant against input 0 through backpressure.
    fi = 0;
    for (int c = 0; c < 5; c++) begin
      in_data[2] = flits[fi];
      req(4'b0101, srdy_pat[c], srdy_pat[c] ? 4'b0100 : 4'b0000, 1'b1,
          $sformatf("lock%0d", c));
      if (srdy_pat[c]) fi++;
    end
    req(4'b0001, 1'b1, 4'b0001, 1'b1, "after_tail");

    // Reset mid-packet: request lock with cnt=2, FIFO count 3.
    do_reset();
    in_data[2] = 8'h83;
    req(4'b0011, 1'b1, 4'b0001, 1'b1, "mp0");
    req(4'b0010, 1'b1, 4'b0010, 1'b1, "mp1");
    req(4'b0100, 1'b1, 4'b0100, 1'b1, "mp_hdr");
    in_data[2] = 8'h91;
    req(4'b0100, 1'b1, 4'b0100, 1'b1, "mp_b1");
    reset = 1'b1; in_v = 4'hF; single_v = 1'b1; single_data = 8'h00; in_ready = 4'hF;
    #2;
    check("mprst_so_v", so_v, 1'b0);
    check("mprst_so_rdy", so_rdy, 1'b0);
    check("mprst_lo_v", lo_v, 4'h0);
    check("mprst_lo_rdy", lo_rdy, 4'h0);
    cyc();
    reset = 1'b0; in_v = 4'b1001;
    #2;
    check("post_empty_srdy", so_rdy, 1'b0);
    check("post_empty_lo_v", lo_v, 4'h0);
    check("post_grant", lo_rdy, 4'b0001);
    exp_q.push_back(in_data[0]);
    cyc();
    single_v = 1'b0; in_v = '0;
    check("sb_drained", exp_q.size(), 0);

    // Depth-2 FIFO: third header waits for a response tail, then goes next cycle.
    sb_en = 1'b0;
    do_reset();
    single_rdy = 1'b1; in_ready = 4'hF;
    in_v = 4'b0111; #2; check("full_g0", lo2_rdy, 4'b0001); cyc();
    in_v = 4'b0110; #2; check("full_g1", lo2_rdy, 4'b0010); cyc();
    in_v = 4'b0100; #2;
    check("full_stall_rdy", lo2_rdy, 4'b0000);
    check("full_stall_v", so2_v, 1'b0);
    cyc();
    single_v = 1'b1; single_data = 8'h00; #2;
    check("full_pop_srdy", so2_rdy, 1'b1);
    check("full_pop_rdy", lo2_rdy, 4'b0000);
    cyc();
    single_v = 1'b0; #2;
    check("full_after_pop", lo2_rdy, 4'b0100);
    check("full_after_pop_v", so2_v, 1'b1);
    cyc();
    in_v = '0;

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
